// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if: configuration write port of the multi-channel LED driver.
//   cfg_we    single-cycle write strobe
//   cfg_ch    target channel (values >= NUM_CH are ignored by the driver)
//   cfg_mode  0=OFF, 1=ON, 2=BLINK, 3=BREATHE
//   cfg_duty  brightness, or breathe peak level
//   cfg_rate  frames per blink half-period / breathe step, minus 1
// The master modport belongs to whoever issues writes (top level or a register bank).
// The slave modport belongs to the LED driver.
interface led_pattern_gen_if #(
  parameter int NUM_CH   = 3,
  parameter int PWM_BITS = 8,
  parameter int CH_BITS  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic                cfg_we;
  logic [CH_BITS-1:0]  cfg_ch;
  logic [1:0]          cfg_mode;
  logic [PWM_BITS-1:0] cfg_duty;
  logic [7:0]          cfg_rate;

  modport master (
    output cfg_we, cfg_ch, cfg_mode, cfg_duty, cfg_rate
  );

  modport slave (
    input cfg_we, cfg_ch, cfg_mode, cfg_duty, cfg_rate
  );
endinterface

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel PWM LED driver with OFF / ON / BLINK / BREATHE modes.
//   clk         system clock
//   rst_n       synchronous active-low reset
//   cfg         configuration write port (led_pattern_gen_if.slave)
//   led         registered LED drive, active-high, one bit per channel
//   frame_tick  one-cycle pulse in the cycle after each PWM frame boundary
// A shared prescaler and PWM counter define the frame; each channel compares the
// counter against an effective duty that is only reloaded at frame boundaries, so
// a duty change never produces a partial pulse.
module led_pattern_gen #(
  parameter int NUM_CH   = 3,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 187,
  parameter int CH_BITS  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  led_pattern_gen_if.slave   cfg,
  output logic [NUM_CH-1:0]  led,
  output logic               frame_tick
);

  localparam int PS_BITS = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_BITS-1:0]  PS_LAST = PS_BITS'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  logic [PS_BITS-1:0]  presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                frame_tick_q, frame_tick_d;
  logic [NUM_CH-1:0]   led_q, led_d;
  logic                tick;
  logic                boundary;
  logic [NUM_CH-1:0]   wr;

  mode_e               mode_q   [NUM_CH];
  mode_e               mode_d   [NUM_CH];
  logic [PWM_BITS-1:0] duty_q   [NUM_CH];
  logic [PWM_BITS-1:0] duty_d   [NUM_CH];
  logic [7:0]          rate_q   [NUM_CH];
  logic [7:0]          rate_d   [NUM_CH];
  logic [7:0]          fcnt_q   [NUM_CH];
  logic [7:0]          fcnt_d   [NUM_CH];
  logic                phase_q  [NUM_CH];
  logic                phase_d  [NUM_CH];
  logic [PWM_BITS-1:0] lvl_q    [NUM_CH];
  logic [PWM_BITS-1:0] lvl_d    [NUM_CH];
  logic                dir_up_q [NUM_CH];
  logic                dir_up_d [NUM_CH];
  logic [PWM_BITS-1:0] eff_q    [NUM_CH];
  logic [PWM_BITS-1:0] eff_d    [NUM_CH];

  // Shared timebase: prescaler produces the PWM tick, the PWM counter wraps once
  // per frame and that wrap is the frame boundary.
  always_comb begin
    tick         = (presc_q == PS_LAST);
    presc_d      = tick ? '0 : presc_q + 1'b1;
    pwm_cnt_d    = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    boundary     = tick && (pwm_cnt_q == PWM_MAX);
    frame_tick_d = boundary;
  end

  // Channel select decode; out-of-range channel numbers match nothing.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wr[i] = cfg.cfg_we && (cfg.cfg_ch == CH_BITS'(i));
    end
  end

  // Per-channel next state. The boundary update uses the pre-step phase/lvl for
  // the reload, then advances the frame counter and pattern. A write to the same
  // channel is applied last so its register clears win over the boundary step,
  // while eff_duty still takes the pre-write settings.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      mode_d[i]   = mode_q[i];
      duty_d[i]   = duty_q[i];
      rate_d[i]   = rate_q[i];
      fcnt_d[i]   = fcnt_q[i];
      phase_d[i]  = phase_q[i];
      lvl_d[i]    = lvl_q[i];
      dir_up_d[i] = dir_up_q[i];
      eff_d[i]    = eff_q[i];
      led_d[i]    = (pwm_cnt_q < eff_q[i]);

      if (boundary) begin
        unique case (mode_q[i])
          MODE_OFF:   eff_d[i] = '0;
          MODE_ON:    eff_d[i] = duty_q[i];
          MODE_BLINK: eff_d[i] = phase_q[i] ? duty_q[i] : '0;
          default:    eff_d[i] = lvl_q[i];
        endcase

        if (mode_q[i] == MODE_BLINK || mode_q[i] == MODE_BREATHE) begin
          if (fcnt_q[i] == rate_q[i]) begin
            fcnt_d[i] = '0;
            if (mode_q[i] == MODE_BLINK) begin
              phase_d[i] = ~phase_q[i];
            end else if (lvl_q[i] > duty_q[i]) begin
              // Peak was lowered below the current level: clamp and head down.
              lvl_d[i]    = duty_q[i];
              dir_up_d[i] = 1'b0;
            end else if (duty_q[i] == '0) begin
              lvl_d[i] = '0;
            end else if (dir_up_q[i]) begin
              if (lvl_q[i] != PWM_MAX) begin
                lvl_d[i] = lvl_q[i] + 1'b1;
              end
              if (({1'b0, lvl_q[i]} + 1'b1) == {1'b0, duty_q[i]}) begin
                dir_up_d[i] = 1'b0;
              end
            end else begin
              if (lvl_q[i] != '0) begin
                lvl_d[i] = lvl_q[i] - 1'b1;
              end
              if (lvl_q[i] == PWM_BITS'(1)) begin
                dir_up_d[i] = 1'b1;
              end
            end
          end else begin
            fcnt_d[i] = fcnt_q[i] + 1'b1;
          end
        end
      end

      if (wr[i]) begin
        mode_d[i]   = mode_e'(cfg.cfg_mode);
        duty_d[i]   = cfg.cfg_duty;
        rate_d[i]   = cfg.cfg_rate;
        fcnt_d[i]   = '0;
        phase_d[i]  = 1'b1;
        lvl_d[i]    = '0;
        dir_up_d[i] = 1'b1;
      end
    end
  end

  // State registers with synchronous reset; reset discards any frame in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q      <= '0;
      pwm_cnt_q    <= '0;
      frame_tick_q <= 1'b0;
      led_q        <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i]   <= MODE_OFF;
        duty_q[i]   <= '0;
        rate_q[i]   <= '0;
        fcnt_q[i]   <= '0;
        phase_q[i]  <= 1'b1;
        lvl_q[i]    <= '0;
        dir_up_q[i] <= 1'b1;
        eff_q[i]    <= '0;
      end
    end else begin
      presc_q      <= presc_d;
      pwm_cnt_q    <= pwm_cnt_d;
      frame_tick_q <= frame_tick_d;
      led_q        <= led_d;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i]   <= mode_d[i];
        duty_q[i]   <= duty_d[i];
        rate_q[i]   <= rate_d[i];
        fcnt_q[i]   <= fcnt_d[i];
        phase_q[i]  <= phase_d[i];
        lvl_q[i]    <= lvl_d[i];
        dir_up_q[i] <= dir_up_d[i];
        eff_q[i]    <= eff_d[i];
      end
    end
  end

  assign led        = led_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scoreboard bench for led_pattern_gen (PWM_BITS=4, PRESCALE=2).
// The stimulus process drives writes/resets and advances a frame-level reference
// model, pushing the expected per-channel brightness for each new frame. A
// separate monitor captures every frame of led output between frame_tick pulses
// and compares it with the expected "on for the first duty*PRESCALE clocks" shape.
module tb_led_pattern_gen;

  localparam int NUM_CH   = 3;
  localparam int PWM_BITS = 4;
  localparam int PRESCALE = 2;
  localparam int CH_BITS  = 2;
  localparam int LEVELS   = 1 << PWM_BITS;
  localparam int FRAME    = LEVELS * PRESCALE;

  typedef logic [NUM_CH-1:0][PWM_BITS-1:0] eff_vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] led;
  logic              frame_tick;

  led_pattern_gen_if #(.NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .CH_BITS(CH_BITS)) cfg_bus ();

  led_pattern_gen #(
    .NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE), .CH_BITS(CH_BITS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg(cfg_bus),
    .led(led),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: per-channel settings and pattern position, advanced once per frame.
  int m_mode  [NUM_CH];
  int m_duty  [NUM_CH];
  int m_rate  [NUM_CH];
  int m_fcnt  [NUM_CH];
  int m_phase [NUM_CH];
  int m_lvl   [NUM_CH];
  int m_up    [NUM_CH];
  int clocks_since_release;
  eff_vec_t exp_q[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  function automatic void model_clear_channel(input int c);
    m_fcnt[c]  = 0;
    m_phase[c] = 1;
    m_lvl[c]   = 0;
    m_up[c]    = 1;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_mode[c] = 0;
      m_duty[c] = 0;
      m_rate[c] = 0;
      model_clear_channel(c);
    end
    clocks_since_release = 0;
    exp_q.delete();
  endfunction

  function automatic void model_breathe_step(input int c);
    if (m_lvl[c] > m_duty[c]) begin
      m_lvl[c] = m_duty[c];
      m_up[c]  = 0;
    end else if (m_duty[c] == 0) begin
      m_lvl[c] = 0;
    end else if (m_up[c] != 0) begin
      if (m_lvl[c] + 1 == m_duty[c]) m_up[c] = 0;
      if (m_lvl[c] < LEVELS - 1) m_lvl[c]++;
    end else begin
      if (m_lvl[c] == 1) m_up[c] = 1;
      if (m_lvl[c] > 0) m_lvl[c]--;
    end
  endfunction

  function automatic void model_boundary();
    eff_vec_t v;
    int e;
    for (int c = 0; c < NUM_CH; c++) begin
      case (m_mode[c])
        0:       e = 0;
        1:       e = m_duty[c];
        2:       e = (m_phase[c] != 0) ? m_duty[c] : 0;
        default: e = m_lvl[c];
      endcase
      v[c] = PWM_BITS'(e);
    end
    exp_q.push_back(v);
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_mode[c] >= 2) begin
        if (m_fcnt[c] == m_rate[c]) begin
          m_fcnt[c] = 0;
          if (m_mode[c] == 2) m_phase[c] = (m_phase[c] != 0) ? 0 : 1;
          else model_breathe_step(c);
        end else begin
          m_fcnt[c]++;
        end
      end
    end
  endfunction

  // Drive one clock of inputs, then advance the model with what the DUT sampled.
  task automatic applyStimulus(input logic rst_v, input logic we, input int ch,
                               input int mode, input int duty, input int rate);
    @(negedge clk);
    rst_n            = rst_v;
    cfg_bus.cfg_we   = we;
    cfg_bus.cfg_ch   = CH_BITS'(ch);
    cfg_bus.cfg_mode = 2'(mode);
    cfg_bus.cfg_duty = PWM_BITS'(duty);
    cfg_bus.cfg_rate = 8'(rate);
    @(posedge clk);
    if (!rst_v) begin
      model_reset();
    end else begin
      clocks_since_release++;
      if (clocks_since_release % FRAME == 0) model_boundary();
      if (we && ch < NUM_CH) begin
        m_mode[ch] = mode;
        m_duty[ch] = duty;
        m_rate[ch] = rate;
        model_clear_channel(ch);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic write_cfg(input int ch, input int mode, input int duty, input int rate);
    applyStimulus(1'b1, 1'b1, ch, mode, duty, rate);
  endtask

  task automatic hold_reset(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'(k % 2), k % 4, 1, 5, 0);
  endtask

  // Monitor: capture led per frame, compare at the closing frame_tick, pop the next expectation.
  initial begin : monitor
    logic [FRAME-1:0] cap [NUM_CH];
    logic [FRAME-1:0] want;
    eff_vec_t cur;
    bit have_frame = 0;
    bit first_seen = 0;
    int pos = 0;
    int since_rel = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        have_frame = 0;
        first_seen = 0;
        since_rel  = 0;
        checkOutput("reset_led", 64'(led), 64'd0);
        checkOutput("reset_frame_tick", 64'(frame_tick), 64'd0);
      end else begin
        since_rel++;
        if (frame_tick) begin
          if (!first_seen) begin
            first_seen = 1;
            checkOutput("first_frame_tick_delay", 64'(since_rel), 64'(FRAME));
          end
          if (have_frame) begin
            checkOutput("frame_length", 64'(pos + 1), 64'(FRAME));
            for (int c = 0; c < NUM_CH; c++) begin
              cap[c][FRAME-1] = led[c];
              for (int j = 0; j < FRAME; j++) want[j] = (j < int'(cur[c]) * PRESCALE);
              checkOutput($sformatf("frame_pattern_ch%0d_duty%0d", c, cur[c]), 64'(cap[c]), 64'(want));
            end
          end
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_frame_tick", 64'd1, 64'd0);
            have_frame = 0;
          end else begin
            cur = exp_q.pop_front();
            have_frame = 1;
          end
          pos = 0;
          for (int c = 0; c < NUM_CH; c++) cap[c] = '0;
        end else if (have_frame) begin
          pos++;
          if (pos < FRAME) begin
            for (int c = 0; c < NUM_CH; c++) cap[c][pos-1] = led[c];
          end else begin
            checkOutput("frame_tick_overdue", 64'(pos), 64'(FRAME - 1));
            have_frame = 0;
          end
        end
      end
    end
  end

  initial begin : stimulus
    int r;
    cfg_bus.cfg_we   = 1'b0;
    cfg_bus.cfg_ch   = '0;
    cfg_bus.cfg_mode = '0;
    cfg_bus.cfg_duty = '0;
    cfg_bus.cfg_rate = '0;
    model_reset();

    $display("[TB] reset with write strobes pulsing");
    hold_reset(5);
    idle(FRAME + 8);

    $display("[TB] ON mode on ch0: duty 4, 0, 15");
    write_cfg(0, 1, 4, 0);
    idle(2 * FRAME);
    write_cfg(0, 1, 0, 0);
    idle(2 * FRAME);
    write_cfg(0, 1, 15, 0);
    idle(2 * FRAME);
    write_cfg(0, 1, 4, 0);

    $display("[TB] BLINK on ch1: duty 8, rate 1");
    write_cfg(1, 2, 8, 1);
    idle(6 * FRAME);

    $display("[TB] BREATHE on ch2: peak 3, then peak lowered to 1");
    write_cfg(2, 3, 3, 0);
    idle(9 * FRAME);
    write_cfg(2, 3, 1, 0);
    idle(4 * FRAME);

    $display("[TB] write landing on the frame boundary, then out-of-range channel");
    while ((clocks_since_release + 1) % FRAME != 0) idle(1);
    write_cfg(0, 1, 10, 0);
    idle(3 * FRAME);
    write_cfg(3, 1, 15, 0);
    idle(2 * FRAME);

    $display("[TB] reset in the middle of a breathe ramp");
    write_cfg(2, 3, 5, 0);
    idle(3 * FRAME + 11);
    hold_reset(3);
    idle(3 * FRAME);

    $display("[TB] randomized configuration traffic");
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 1499));
      if (r == 0) begin
        hold_reset(2);
      end else if (r < 50) begin
        write_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, LEVELS - 1)), int'($urandom_range(0, 3)));
      end else begin
        idle(1);
      end
    end
    idle(2 * FRAME + 2);
    #2;
    checkOutput("pending_expected_frames", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
